uart_tx_sched: RTL and testbench

- Transmit scheduler that shares the uart_codec serial transmit path (txsd/txck) between two word requesters.
- Arbitrates round-robin between requesters, splits each accepted word into bytes (MSB byte first), and sequences the codec byte-by-byte using its busy/done status.
- Counts completed words for the 7-segment display.
- Flags a sticky error if the codec fails to report completion within a timeout.

---
 rtl/uart_tx_sched_if.sv | 29 ++
 rtl/uart_tx_sched.sv | 129 ++++++++++++
 tb/tb_uart_tx_sched.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_if.sv
// Request, codec and status signals of the two-requester UART transmit scheduler.
// master is the scheduler side; slave is the requesters/codec/display side.
interface uart_tx_sched_if #(
  parameter int DATA_W = 16
);
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              tx_start;
  logic [7:0]        tx_byte;
  logic              tx_busy;
  logic              tx_done;
  logic [1:0]        grant;
  logic [15:0]       word_cnt;
  logic              err_timeout;

  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data, tx_busy, tx_done,
    output req0_ready, req1_ready, tx_start, tx_byte, grant, word_cnt, err_timeout
  );

  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data, tx_busy, tx_done,
    input  req0_ready, req1_ready, tx_start, tx_byte, grant, word_cnt, err_timeout
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin word scheduler onto the UART codec, MSB byte first; ready 1 cycle after valid, tx_start >= 2 cycles.
// Backpressure: requester holds valid until its ready pulse; codec busy stalls tx_start; missing tx_done times out.
module uart_tx_sched #(
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic            clk,
  input  logic            btnl,
  uart_tx_sched_if.master bus
);
  localparam int NB = DATA_W / 8;
  localparam int CW = $clog2(NB + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);
  // Timer counts from 0 in the tx_start cycle, so T-2 is the last cycle tx_done may still arrive
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 2);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]     left_q, left_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic              last_q, last_d;
  logic              rdy0_q, rdy0_d;
  logic              rdy1_q, rdy1_d;
  logic              start_q, start_d;
  logic              err_q, err_d;
  logic [7:0]        byte_q, byte_d;
  logic [1:0]        grant_q, grant_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              win;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    left_d  = left_q;
    tmr_d   = tmr_q;
    last_d  = last_q;
    rdy0_d  = 1'b0;
    rdy1_d  = 1'b0;
    start_d = 1'b0;
    err_d   = err_q;
    byte_d  = byte_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    // 1 selects requester 1; on contention the one not served last wins
    win = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;

    case (state_q)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          rdy0_d  = ~win;
          rdy1_d  = win;
          grant_d = win ? 2'b10 : 2'b01;
          shreg_d = win ? bus.req1_data : bus.req0_data;
          left_d  = CW'(NB);
          last_d  = win;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!bus.tx_busy) begin
          start_d = 1'b1;
          byte_d  = shreg_q[DATA_W-1 -: 8];
          tmr_d   = '0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.tx_done) begin
          if (left_q > CW'(1)) begin
            shreg_d = shreg_q << 8;
            left_d  = left_q - CW'(1);
            state_d = SEND;
          end else begin
            cnt_d   = cnt_q + 16'd1;
            grant_d = 2'b00;
            state_d = IDLE;
          end
        end else if (tmr_q == TMO_LAST) begin
          err_d   = 1'b1;
          grant_d = 2'b00;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge btnl) begin
    if (!btnl) begin
      state_q <= IDLE;
      shreg_q <= '0;
      left_q  <= '0;
      tmr_q   <= '0;
      last_q  <= 1'b1;
      rdy0_q  <= 1'b0;
      rdy1_q  <= 1'b0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      byte_q  <= 8'h00;
      grant_q <= 2'b00;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      left_q  <= left_d;
      tmr_q   <= tmr_d;
      last_q  <= last_d;
      rdy0_q  <= rdy0_d;
      rdy1_q  <= rdy1_d;
      start_q <= start_d;
      err_q   <= err_d;
      byte_q  <= byte_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req0_ready  = rdy0_q;
  assign bus.req1_ready  = rdy1_q;
  assign bus.tx_start    = start_q;
  assign bus.tx_byte     = byte_q;
  assign bus.grant       = grant_q;
  assign bus.word_cnt    = cnt_q;
  assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: queued requesters, a codec model, and a timestamp/queue reference
// checked every cycle, plus directed scenarios with literal expectations.
module tb_uart_tx_sched;
  localparam int DW  = 16;
  localparam int NB  = DW / 8;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic btnl;
  always #5 clk = ~clk;

  uart_tx_sched_if #(.DATA_W(DW)) bus ();
  uart_tx_sched #(.DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (.clk(clk), .btnl(btnl), .bus(bus));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Stimulus state shared by the drivers and the scenario sequence
  logic [DW-1:0] srcq0[$];
  logic [DW-1:0] srcq1[$];
  bit gaps = 0, mute = 0, busy_force = 0, spur_req = 0;

  // Reference model: bytes owed to the codec, plus observation logs
  typedef struct { logic [7:0] b; bit lastb; } xfer_t;
  xfer_t xq[$];
  logic [1:0]  m_grant;
  logic [15:0] m_cnt;
  bit          m_err, infl;
  int          m_last, infl_start;
  bit          p_v0, p_v1, p_busy, p_done, p_infl, p_gidle, p_err;
  logic [DW-1:0] p_d0, p_d1;
  logic [7:0] slog[$];
  logic [1:0] glog[$];
  int last_start_cyc = 0, err_rise_cyc = 0, busy_fall_cyc = 0;

  task automatic mreset();
    xq.delete();
    m_grant = 2'b00; m_cnt = 16'h0; m_err = 0; m_last = 1; infl = 0;
    p_v0 = 0; p_v1 = 0; p_busy = 0; p_done = 0; p_infl = 0; p_gidle = 1; p_err = 0;
  endtask

  // Requesters and codec
  initial begin
    bit acc0, acc1, cb;
    int cc;
    cc = 0; cb = 0;
    forever begin
      @(negedge clk);
      acc0 = bus.req0_valid && bus.req0_ready;
      acc1 = bus.req1_valid && bus.req1_ready;
      @(posedge clk);
      #1;
      if (!btnl) begin
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.tx_done = 0; cc = 0; cb = 0;
        bus.tx_busy = busy_force;
      end else begin
        if (acc0) begin void'(srcq0.pop_front()); bus.req0_valid = 0; bus.req0_data = DW'($urandom); end
        if (acc1) begin void'(srcq1.pop_front()); bus.req1_valid = 0; bus.req1_data = DW'($urandom); end
        if (!bus.req0_valid && srcq0.size() > 0 && (!gaps || $urandom_range(0, 2) == 0)) begin
          bus.req0_valid = 1; bus.req0_data = srcq0[0];
        end
        if (!bus.req1_valid && srcq1.size() > 0 && (!gaps || $urandom_range(0, 2) == 0)) begin
          bus.req1_valid = 1; bus.req1_data = srcq1[0];
        end
        bus.tx_done = 0;
        if (cc > 0) begin
          cc--;
          if (cc == 0) begin bus.tx_done = 1; cb = 0; end
        end
        if (bus.tx_start && !mute) begin
          cc = gaps ? int'($urandom_range(1, 12)) : 10;
          cb = 1;
        end
        if (spur_req) begin bus.tx_done = 1; spur_req = 0; end
        bus.tx_busy = cb | busy_force;
      end
    end
  end

  // Per-cycle compare against the reference
  initial begin
    bit e_r0, e_r1, e_s;
    int w;
    logic [DW-1:0] wd;
    xfer_t x;
    mreset();
    forever begin
      @(negedge clk);
      cyc++;
      if (!btnl) begin
        mreset();
      end else begin
        if (p_infl) begin
          if (p_done) begin
            x = xq.pop_front();
            infl = 0;
            if (x.lastb) begin m_cnt = m_cnt + 16'd1; m_grant = 2'b00; end
          end else if ((cyc - 1 - infl_start) == TMO - 2) begin
            m_err = 1; infl = 0; m_grant = 2'b00; xq.delete();
          end
        end
        e_r0 = 0; e_r1 = 0;
        if (p_gidle && (p_v0 || p_v1)) begin
          w = (p_v0 && p_v1) ? 1 - m_last : (p_v0 ? 0 : 1);
          if (w == 0) e_r0 = 1; else e_r1 = 1;
          m_last = w;
          m_grant = (w == 1) ? 2'b10 : 2'b01;
          wd = (w == 1) ? p_d1 : p_d0;
          for (int k = 0; k < NB; k++) begin
            x.b = wd[8*(NB-1-k) +: 8];
            x.lastb = (k == NB - 1);
            xq.push_back(x);
          end
        end
        chk("req0_ready", bus.req0_ready, e_r0);
        chk("req1_ready", bus.req1_ready, e_r1);
        if (bus.req0_ready || bus.req1_ready) glog.push_back(bus.grant);
        e_s = !p_gidle && !p_infl && !p_busy && xq.size() > 0;
        chk("tx_start", bus.tx_start, e_s);
        if (bus.tx_start) begin
          slog.push_back(bus.tx_byte);
          last_start_cyc = cyc;
        end
        if (e_s) begin infl = 1; infl_start = cyc; end
        if (infl) chk("tx_byte", bus.tx_byte, xq[0].b);
        chk("grant", bus.grant, m_grant);
        chk("word_cnt", bus.word_cnt, m_cnt);
        chk("err_timeout", bus.err_timeout, m_err);
        if (bus.err_timeout && !p_err) err_rise_cyc = cyc;
        if (!bus.tx_busy && p_busy) busy_fall_cyc = cyc;
        p_v0 = bus.req0_valid; p_v1 = bus.req1_valid;
        p_d0 = bus.req0_data;  p_d1 = bus.req1_data;
        p_busy = bus.tx_busy;  p_done = bus.tx_done;
        p_infl = infl; p_gidle = (m_grant == 2'b00); p_err = bus.err_timeout;
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdy0"}, bus.req0_ready, 0);
    chk({tag, "_rdy1"}, bus.req1_ready, 0);
    chk({tag, "_start"}, bus.tx_start, 0);
    chk({tag, "_err"}, bus.err_timeout, 0);
    chk({tag, "_byte"}, bus.tx_byte, 8'h00);
    chk({tag, "_grant"}, bus.grant, 2'b00);
    chk({tag, "_cnt"}, bus.word_cnt, 16'h0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    srcq0.delete(); srcq1.delete();
    btnl = 0;
    #1;
    chk_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 btnl = 1;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = srcq0.size() == 0 && srcq1.size() == 0 && !bus.req0_valid && !bus.req1_valid &&
           m_grant == 2'b00 && xq.size() == 0 && !bus.tx_busy;
    end
    chk("wait_idle", ok, 1);
  endtask

  task automatic wait_slog(input int n, input int budget);
    int i = 0;
    while (slog.size() < n && i < budget) begin @(negedge clk); #1; i++; end
    chk("wait_start", slog.size() >= n, 1);
  endtask

  initial begin
    logic [15:0] base;
    bit rnd_done;
    int i;
    bus.req0_valid = 0; bus.req1_valid = 0; bus.req0_data = '0; bus.req1_data = '0;
    bus.tx_busy = 0; bus.tx_done = 0;
    btnl = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    #1 btnl = 1;

    // Single word from requester 0
    slog.delete(); glog.delete();
    srcq0.push_back(16'hA55A);
    wait_idle(400);
    chk("t1_nbytes", slog.size(), 2);
    if (slog.size() == 2) begin chk("t1_b0", slog[0], 8'hA5); chk("t1_b1", slog[1], 8'h5A); end
    chk("t1_ngrant", glog.size(), 1);
    if (glog.size() == 1) chk("t1_grant", glog[0], 2'b01);
    chk("t1_cnt", bus.word_cnt, 16'd1);

    // Simultaneous requests right after reset
    do_reset();
    slog.delete(); glog.delete();
    srcq0.push_back(16'h1234);
    srcq1.push_back(16'hBEEF);
    wait_idle(400);
    chk("t2_nbytes", slog.size(), 4);
    if (slog.size() == 4) begin
      chk("t2_b0", slog[0], 8'h12); chk("t2_b1", slog[1], 8'h34);
      chk("t2_b2", slog[2], 8'hBE); chk("t2_b3", slog[3], 8'hEF);
    end
    chk("t2_ngrant", glog.size(), 2);
    if (glog.size() == 2) begin chk("t2_g0", glog[0], 2'b01); chk("t2_g1", glog[1], 2'b10); end
    chk("t2_cnt", bus.word_cnt, 16'd2);

    // Fairness under continuous contention
    slog.delete(); glog.delete();
    base = bus.word_cnt;
    for (i = 0; i < 3; i++) begin srcq0.push_back(DW'($urandom)); srcq1.push_back(DW'($urandom)); end
    wait_idle(1500);
    chk("t3_ngrant", glog.size(), 6);
    for (i = 0; i < glog.size(); i++) chk("t3_alt", glog[i], (i % 2 == 1) ? 2'b10 : 2'b01);
    chk("t3_nbytes", slog.size(), 12);
    chk("t3_cnt", bus.word_cnt, base + 16'd6);

    // Codec never finishes: timeout, then a normal word
    slog.delete(); glog.delete();
    base = bus.word_cnt;
    mute = 1;
    srcq0.push_back(DW'($urandom));
    wait_idle(400);
    chk("t4_err", bus.err_timeout, 1);
    chk("t4_err_delay", err_rise_cyc - last_start_cyc, 15);
    chk("t4_cnt", bus.word_cnt, base);
    chk("t4_nbytes", slog.size(), 1);
    mute = 0;
    srcq1.push_back(16'h00FF);
    wait_idle(400);
    chk("t4_nbytes2", slog.size(), 3);
    if (slog.size() == 3) begin chk("t4_b1", slog[1], 8'h00); chk("t4_b2", slog[2], 8'hFF); end
    chk("t4_cnt2", bus.word_cnt, base + 16'd1);
    chk("t4_err_sticky", bus.err_timeout, 1);

    // Busy gating, then a spurious tx_done while idle
    slog.delete(); glog.delete();
    busy_force = 1;
    repeat (2) @(posedge clk);
    srcq1.push_back(DW'($urandom));
    i = 0;
    while (glog.size() == 0 && i < 20) begin @(negedge clk); #1; i++; end
    chk("t5_accept", glog.size(), 1);
    repeat (50) @(posedge clk);
    chk("t5_no_start", slog.size(), 0);
    busy_force = 0;
    wait_slog(1, 20);
    chk("t5_start_after_fall", last_start_cyc - busy_fall_cyc, 1);
    wait_idle(400);
    base = bus.word_cnt;
    spur_req = 1;
    repeat (5) @(posedge clk);
    chk("t5_spurious", bus.word_cnt, base);

    // Reset in the middle of a word, then resubmit
    slog.delete(); glog.delete();
    srcq0.push_back(16'hA55A);
    wait_slog(1, 40);
    repeat (3) @(posedge clk);
    do_reset();
    slog.delete(); glog.delete();
    srcq0.push_back(16'hA55A);
    wait_idle(400);
    chk("t6_nbytes", slog.size(), 2);
    if (slog.size() == 2) begin chk("t6_b0", slog[0], 8'hA5); chk("t6_b1", slog[1], 8'h5A); end
    chk("t6_cnt", bus.word_cnt, 16'd1);

    // Randomized traffic with gaps, random codec timing and busy bursts
    gaps = 1;
    base = bus.word_cnt;
    for (i = 0; i < 30; i++) begin srcq0.push_back(DW'($urandom)); srcq1.push_back(DW'($urandom)); end
    rnd_done = 0;
    fork
      begin wait_idle(20000); rnd_done = 1; end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #2 busy_force = ($urandom_range(0, 5) == 0);
        end
        busy_force = 0;
      end
    join
    busy_force = 0;
    repeat (3) @(posedge clk);
    chk("t7_cnt", bus.word_cnt, base + 16'd60);
    chk("t7_err", bus.err_timeout, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
